// File: rtl/async_fifo1_if.sv
// ---------------------------------------------------------------------------
// async_fifo1_if : write/read handshake bundle for async_fifo1
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface async_fifo1_if #(
  parameter int DSIZE = 8
);
  logic             winc;
  logic [DSIZE-1:0] wdata;
  logic             rinc;
  logic [DSIZE-1:0] rdata;
  logic             wfull;
  logic             rempty;

  modport master (
    output winc, wdata, rinc,
    input  rdata, wfull, rempty
  );

  modport slave (
    input  winc, wdata, rinc,
    output rdata, wfull, rempty
  );
endinterface

`default_nettype wire

// File: rtl/async_fifo1.sv
// ---------------------------------------------------------------------------
// async_fifo1 : Gray-pointer FIFO with 2-flop pointer synchronizers, one clock
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module async_fifo1 #(
  parameter int DSIZE = 8,
  parameter int ASIZE = 8
) (
  input  logic           wclk,
  input  logic           wrst_n,
  async_fifo1_if.slave   fifo
);

  localparam int DEPTH = 1 << ASIZE;

  logic [DSIZE-1:0] mem_q [DEPTH];

  logic [ASIZE:0] wbin_q, wbin_d, wptr_q, wgray_d;
  logic [ASIZE:0] rbin_q, rbin_d, rptr_q, rgray_d;
  logic [ASIZE:0] wq1_rptr_q, wq2_rptr_q;
  logic [ASIZE:0] rq1_wptr_q, rq2_wptr_q;
  logic           wfull_q, wfull_d;
  logic           rempty_q, rempty_d;
  logic           wr_en, rd_en;

  always_comb begin
    wr_en    = fifo.winc && !wfull_q;
    rd_en    = fifo.rinc && !rempty_q;
    wbin_d   = wbin_q + {{ASIZE{1'b0}}, wr_en};
    rbin_d   = rbin_q + {{ASIZE{1'b0}}, rd_en};
    wgray_d  = (wbin_d >> 1) ^ wbin_d;
    rgray_d  = (rbin_d >> 1) ^ rbin_d;
    // Full when the write pointer has lapped the read pointer: top two Gray bits inverted.
    wfull_d  = (wgray_d == {~wq2_rptr_q[ASIZE:ASIZE-1], wq2_rptr_q[ASIZE-2:0]});
    rempty_d = (rgray_d == rq2_wptr_q);
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin_q     <= '0;
      wptr_q     <= '0;
      rbin_q     <= '0;
      rptr_q     <= '0;
      wq1_rptr_q <= '0;
      wq2_rptr_q <= '0;
      rq1_wptr_q <= '0;
      rq2_wptr_q <= '0;
      wfull_q    <= 1'b0;
      rempty_q   <= 1'b1;
    end else begin
      wbin_q     <= wbin_d;
      wptr_q     <= wgray_d;
      rbin_q     <= rbin_d;
      rptr_q     <= rgray_d;
      wq1_rptr_q <= rptr_q;
      wq2_rptr_q <= wq1_rptr_q;
      rq1_wptr_q <= wptr_q;
      rq2_wptr_q <= rq1_wptr_q;
      wfull_q    <= wfull_d;
      rempty_q   <= rempty_d;
    end
  end

  // Storage is deliberately left unreset; pointer reset makes old words unreachable.
  always_ff @(posedge wclk) begin
    if (wr_en) begin
      mem_q[wbin_q[ASIZE-1:0]] <= fifo.wdata;
    end
  end

  assign fifo.rdata  = mem_q[rbin_q[ASIZE-1:0]];
  assign fifo.wfull  = wfull_q;
  assign fifo.rempty = rempty_q;

endmodule

`default_nettype wire

// File: tb/tb_async_fifo1.sv
// ---------------------------------------------------------------------------
// tb_async_fifo1 : directed vector and sequence checks for async_fifo1
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_async_fifo1;

  logic wclk;
  logic wrst_n;
  int   total;
  int   bad;

  async_fifo1_if #(.DSIZE(8)) bus ();

  async_fifo1 #(.DSIZE(8), .ASIZE(8)) dut (
    .wclk   (wclk),
    .wrst_n (wrst_n),
    .fifo   (bus.slave)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  typedef struct {
    logic       winc;
    logic [7:0] wdata;
    logic       rinc;
    logic       exp_empty;
    logic       exp_full;
    logic       chk_data;
    logic [7:0] exp_rdata;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled on the next falling edge.
  task automatic tick();
    @(posedge wclk);
    @(negedge wclk);
  endtask

  initial begin
    int wc;
    int rc;
    int cyc;
    total = 0;
    bad   = 0;
    bus.winc  = 1'b0;
    bus.rinc  = 1'b0;
    bus.wdata = 8'h00;
    wrst_n    = 1'b0;

    // Single-word latency, pop-to-empty, read-while-empty, simultaneous ops.
    vecs[0]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[1]  = '{1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[2]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[3]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5};
    vecs[5]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[6]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[7]  = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[8]  = '{1'b1, 8'h22, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11};
    vecs[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h22};
    vecs[12] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};

    // Reset held across several edges, released on a falling edge.
    #25;
    check("rst_empty", {31'd0, bus.rempty}, 32'd1);
    check("rst_full",  {31'd0, bus.wfull},  32'd0);
    @(negedge wclk);
    wrst_n = 1'b1;
    repeat (3) tick();
    check("post_rst_empty", {31'd0, bus.rempty}, 32'd1);
    check("post_rst_full",  {31'd0, bus.wfull},  32'd0);

    for (int i = 0; i < 13; i++) begin
      bus.winc  = vecs[i].winc;
      bus.wdata = vecs[i].wdata;
      bus.rinc  = vecs[i].rinc;
      tick();
      check($sformatf("vec%0d_empty", i), {31'd0, bus.rempty}, {31'd0, vecs[i].exp_empty});
      check($sformatf("vec%0d_full", i),  {31'd0, bus.wfull},  {31'd0, vecs[i].exp_full});
      if (vecs[i].chk_data)
        check($sformatf("vec%0d_rdata", i), {24'd0, bus.rdata}, {24'd0, vecs[i].exp_rdata});
    end
    bus.winc = 1'b0;
    bus.rinc = 1'b0;
    repeat (3) tick();

    // Fill to full, overflow write dropped, drain in order.
    for (int i = 0; i < 256; i++) begin
      bus.winc  = 1'b1;
      bus.wdata = i[7:0];
      tick();
      check($sformatf("fill%0d_full", i), {31'd0, bus.wfull}, (i == 255) ? 32'd1 : 32'd0);
    end
    bus.wdata = 8'h55;
    repeat (3) begin
      tick();
      check("overflow_full", {31'd0, bus.wfull}, 32'd1);
    end
    bus.winc = 1'b0;
    repeat (3) tick();
    for (int i = 0; i < 256; i++) begin
      check($sformatf("drain%0d_notempty", i), {31'd0, bus.rempty}, 32'd0);
      check($sformatf("drain%0d_rdata", i), {24'd0, bus.rdata}, i);
      bus.rinc = 1'b1;
      tick();
      check($sformatf("drain%0d_full", i), {31'd0, bus.wfull}, (i < 3) ? 32'd1 : 32'd0);
      check($sformatf("drain%0d_empty", i), {31'd0, bus.rempty}, (i == 255) ? 32'd1 : 32'd0);
    end
    bus.rinc = 1'b0;
    repeat (3) tick();

    // 512-word burst with concurrent reads; pointers wrap past 256 and 511.
    wc  = 0;
    rc  = 0;
    cyc = 0;
    while ((rc < 512) && (cyc < 5000)) begin
      bus.winc  = (wc < 512) && !bus.wfull;
      bus.wdata = wc[7:0];
      bus.rinc  = !bus.rempty;
      if (bus.rinc) check("burst_rdata", {24'd0, bus.rdata}, rc & 255);
      if (bus.winc) wc++;
      if (bus.rinc) rc++;
      tick();
      cyc++;
    end
    bus.winc = 1'b0;
    bus.rinc = 1'b0;
    check("burst_count", rc, 32'd512);
    repeat (3) tick();
    check("burst_end_empty", {31'd0, bus.rempty}, 32'd1);

    // Read request held while empty must not move the read pointer.
    bus.rinc = 1'b1;
    repeat (5) begin
      tick();
      check("rguard_empty", {31'd0, bus.rempty}, 32'd1);
    end
    bus.rinc  = 1'b0;
    bus.winc  = 1'b1;
    bus.wdata = 8'h77;
    tick();
    bus.winc = 1'b0;
    repeat (2) tick();
    check("rguard_empty_k2", {31'd0, bus.rempty}, 32'd1);
    tick();
    check("rguard_empty_k3", {31'd0, bus.rempty}, 32'd0);
    check("rguard_rdata", {24'd0, bus.rdata}, 32'h77);
    bus.rinc = 1'b1;
    tick();
    bus.rinc = 1'b0;
    check("rguard_pop_empty", {31'd0, bus.rempty}, 32'd1);
    repeat (3) tick();

    // Write request held while full; release timing after a single pop.
    for (int i = 0; i < 256; i++) begin
      bus.winc  = 1'b1;
      bus.wdata = i[7:0] ^ 8'h5A;
      tick();
    end
    check("wguard_full", {31'd0, bus.wfull}, 32'd1);
    bus.wdata = 8'hEE;
    repeat (5) begin
      tick();
      check("wguard_hold_full", {31'd0, bus.wfull}, 32'd1);
    end
    bus.winc = 1'b0;
    check("wguard_head", {24'd0, bus.rdata}, 32'h5A);
    bus.rinc = 1'b1;
    tick();
    bus.rinc = 1'b0;
    check("wguard_full_k0", {31'd0, bus.wfull}, 32'd1);
    tick();
    check("wguard_full_k1", {31'd0, bus.wfull}, 32'd1);
    tick();
    check("wguard_full_k2", {31'd0, bus.wfull}, 32'd1);
    tick();
    check("wguard_full_k3", {31'd0, bus.wfull}, 32'd0);
    for (int i = 1; i < 256; i++) begin
      check($sformatf("wguard_drain%0d", i), {24'd0, bus.rdata}, {24'd0, i[7:0] ^ 8'h5A});
      bus.rinc = 1'b1;
      tick();
    end
    bus.rinc = 1'b0;
    check("wguard_drain_empty", {31'd0, bus.rempty}, 32'd1);
    repeat (3) tick();

    // Asynchronous reset in the middle of traffic.
    for (int i = 0; i < 10; i++) begin
      bus.winc  = 1'b1;
      bus.wdata = 8'hC0 + i[7:0];
      tick();
    end
    bus.winc = 1'b0;
    repeat (3) tick();
    check("mid_pre_empty", {31'd0, bus.rempty}, 32'd0);
    #2;
    wrst_n = 1'b0;
    #1;
    check("mid_rst_empty", {31'd0, bus.rempty}, 32'd1);
    check("mid_rst_full",  {31'd0, bus.wfull},  32'd0);
    repeat (2) @(negedge wclk);
    wrst_n    = 1'b1;
    bus.winc  = 1'b1;
    bus.wdata = 8'h3C;
    tick();
    bus.winc = 1'b0;
    repeat (3) tick();
    check("mid_after_empty", {31'd0, bus.rempty}, 32'd0);
    check("mid_after_rdata", {24'd0, bus.rdata}, 32'h3C);
    bus.rinc = 1'b1;
    tick();
    bus.rinc = 1'b0;
    check("mid_after_pop_empty", {31'd0, bus.rempty}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
